// File: rtl/deserializer.sv
// Bit-destuffing serial-to-parallel receiver.
//
// Samples a one-bit serial line MSB-first on the rising edge of clk_i. With stuffing
// enabled it removes stuffed zeros, recognises 0x7E flags and abort runs (seven ones),
// and rebuilds bytes inside a frame. With stuffing disabled it is a plain 8-bit shift-in.
//
// Ports:
//   clk_i            sample clock
//   rst_ni           asynchronous active-low reset
//   data_in_i        serial line, idle high
//   use_stuffing_i   1 = destuff/flag/abort processing, 0 = raw shift-in
//   data_out_o       last assembled byte, first-received bit in [7]
//   strobe_o         one-cycle pulse, data_out_o valid
//   flag_o           one-cycle pulse per recognised flag
//   frame_end_o      one-cycle pulse on a byte-aligned closing flag after at least one byte
//   frame_error_o    one-cycle pulse on a flag that arrives mid-byte while in a frame
//   abort_o          one-cycle pulse when the run of ones reaches StuffRun+2
module deserializer #(
  parameter int unsigned StuffRun = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       data_in_i,
  input  logic       use_stuffing_i,
  output logic [7:0] data_out_o,
  output logic       strobe_o,
  output logic       flag_o,
  output logic       frame_end_o,
  output logic       frame_error_o,
  output logic       abort_o
);

  localparam logic [2:0] OnesStuff = 3'(StuffRun);
  localparam logic [2:0] OnesFlag  = 3'(StuffRun + 1);
  localparam logic [2:0] OnesSat   = 3'd7;

  logic [2:0] ones_q, ones_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic       in_frame_q, in_frame_d;
  logic       byte_seen_q, byte_seen_d;
  logic       mode_q, mode_d;
  logic [7:0] data_q, data_d;
  logic       strobe_q, strobe_d;
  logic       flag_q, flag_d;
  logic       frame_end_q, frame_end_d;
  logic       frame_error_q, frame_error_d;
  logic       abort_q, abort_d;

  always_comb begin
    ones_d        = ones_q;
    cnt_d         = cnt_q;
    sh_d          = sh_q;
    in_frame_d    = in_frame_q;
    byte_seen_d   = byte_seen_q;
    mode_d        = use_stuffing_i;
    data_d        = data_q;
    strobe_d      = 1'b0;
    flag_d        = 1'b0;
    frame_end_d   = 1'b0;
    frame_error_d = 1'b0;
    abort_d       = 1'b0;

    if (use_stuffing_i != mode_q) begin
      // Mode switch: restart alignment and drop the bit sampled on this edge.
      ones_d      = 3'd0;
      cnt_d       = 3'd0;
      in_frame_d  = 1'b0;
      byte_seen_d = 1'b0;
    end else if (!use_stuffing_i) begin
      sh_d  = {sh_q[6:0], data_in_i};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        data_d   = {sh_q[6:0], data_in_i};
        strobe_d = 1'b1;
      end
    end else if (data_in_i && (ones_q == OnesFlag)) begin
      ones_d      = OnesSat;
      abort_d     = 1'b1;
      in_frame_d  = 1'b0;
      cnt_d       = 3'd0;
      byte_seen_d = 1'b0;
    end else if (!data_in_i && (ones_q == OnesFlag)) begin
      flag_d = 1'b1;
      if (in_frame_q && (cnt_q == 3'd7) && byte_seen_q) frame_end_d = 1'b1;
      if (in_frame_q && (cnt_q != 3'd7)) frame_error_d = 1'b1;
      in_frame_d  = 1'b1;
      cnt_d       = 3'd0;
      byte_seen_d = 1'b0;
      ones_d      = 3'd0;
    end else if (!data_in_i && (ones_q == OnesStuff)) begin
      ones_d = 3'd0;
    end else begin
      // Ordinary data bit; a zero ending an abort/idle run (ones == 7) lands here too.
      sh_d  = {sh_q[6:0], data_in_i};
      cnt_d = cnt_q + 3'd1;
      if (data_in_i) begin
        ones_d = (ones_q == OnesSat) ? OnesSat : ones_q + 3'd1;
      end else begin
        ones_d = 3'd0;
      end
      if ((cnt_q == 3'd7) && in_frame_q) begin
        data_d      = {sh_q[6:0], data_in_i};
        strobe_d    = 1'b1;
        byte_seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ones_q        <= 3'd0;
      cnt_q         <= 3'd0;
      sh_q          <= 8'h00;
      in_frame_q    <= 1'b0;
      byte_seen_q   <= 1'b0;
      mode_q        <= 1'b1;
      data_q        <= 8'h00;
      strobe_q      <= 1'b0;
      flag_q        <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_error_q <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      ones_q        <= ones_d;
      cnt_q         <= cnt_d;
      sh_q          <= sh_d;
      in_frame_q    <= in_frame_d;
      byte_seen_q   <= byte_seen_d;
      mode_q        <= mode_d;
      data_q        <= data_d;
      strobe_q      <= strobe_d;
      flag_q        <= flag_d;
      frame_end_q   <= frame_end_d;
      frame_error_q <= frame_error_d;
      abort_q       <= abort_d;
    end
  end

  assign data_out_o    = data_q;
  assign strobe_o      = strobe_q;
  assign flag_o        = flag_q;
  assign frame_end_o   = frame_end_q;
  assign frame_error_o = frame_error_q;
  assign abort_o       = abort_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: pulses are tallied per bit and compared with
// hand-computed counts and bytes after each stimulus step.
module tb_deserializer;

  logic       clk;
  logic       rst_n;
  logic       data_in;
  logic       use_stuffing;
  logic [7:0] data_out;
  logic       strobe;
  logic       flag;
  logic       frame_end;
  logic       frame_error;
  logic       abort;

  int n_total;
  int n_pass;
  int n_strobe, n_flag, n_fend, n_ferr, n_abort;
  logic [7:0] last_byte;

  deserializer #(.StuffRun(5)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .data_in_i     (data_in),
    .use_stuffing_i(use_stuffing),
    .data_out_o    (data_out),
    .strobe_o      (strobe),
    .flag_o        (flag),
    .frame_end_o   (frame_end),
    .frame_error_o (frame_error),
    .abort_o       (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_tally();
    n_strobe = 0; n_flag = 0; n_fend = 0; n_ferr = 0; n_abort = 0;
  endtask

  // Drive one bit, let it be sampled, then tally outputs 1 time unit after the edge.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk);
    #1;
    if (strobe) begin
      n_strobe++;
      last_byte = data_out;
    end
    if (flag) n_flag++;
    if (frame_end) n_fend++;
    if (frame_error) n_ferr++;
    if (abort) n_abort++;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  initial begin
    n_total = 0;
    n_pass = 0;
    last_byte = 8'h00;
    clear_tally();
    rst_n = 1'b0;
    data_in = 1'b1;
    use_stuffing = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", 32'(data_out), 32'h00);
    check("reset_pulses", 32'({strobe, flag, frame_end, frame_error, abort}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle ones. The 7th consecutive one crosses the abort threshold exactly once.
    clear_tally();
    repeat (40) send_bit(1'b1);
    check("idle_abort_count", 32'(n_abort), 32'd1);
    check("idle_strobe", 32'(n_strobe), 32'd0);
    check("idle_flag", 32'(n_flag + n_fend + n_ferr), 32'd0);
    check("idle_data_out", 32'(data_out), 32'h00);

    // 2: flag, 0x41, flag
    clear_tally();
    send_byte(8'h7E);
    check("f1_open_flag", 32'(n_flag), 32'd1);
    send_byte(8'h41);
    check("f1_strobe", 32'(n_strobe), 32'd1);
    check("f1_byte", 32'(last_byte), 32'h41);
    send_byte(8'h7E);
    check("f1_close_flag_now", 32'(flag), 32'd1);
    check("f1_frame_end_now", 32'(frame_end), 32'd1);
    check("f1_counts", 32'({n_flag[3:0], n_fend[3:0], n_ferr[3:0], n_strobe[3:0]}), 32'h2101);

    // 3: flag, 11111 0(stuffed) 111, flag -> 0xFF
    clear_tally();
    send_byte(8'h7E);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    check("f2_strobe", 32'(n_strobe), 32'd1);
    check("f2_byte", 32'(last_byte), 32'hFF);
    send_byte(8'h7E);
    check("f2_counts", 32'({n_flag[3:0], n_fend[3:0], n_ferr[3:0], n_strobe[3:0]}), 32'h2101);

    // 4: flag, 101, flag. Closing flag bits complete the misaligned slot as 1010_1111,
    // and the flag then arrives at bit count 2.
    clear_tally();
    send_byte(8'h7E);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_byte(8'h7E);
    check("f3_frame_error_now", 32'(frame_error), 32'd1);
    check("f3_counts", 32'({n_flag[3:0], n_fend[3:0], n_ferr[3:0]}), 32'h201);
    check("f3_slot_byte", 32'(last_byte), 32'hAF);

    // 5: flag, 0x55, seven ones, flag
    clear_tally();
    send_byte(8'h7E);
    send_byte(8'h55);
    check("f4_byte", 32'(last_byte), 32'h55);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    check("f4_abort", 32'(n_abort), 32'd1);
    send_byte(8'h7E);
    check("f4_flag_now", 32'(flag), 32'd1);
    check("f4_counts", 32'({n_flag[3:0], n_fend[3:0], n_ferr[3:0], n_strobe[3:0]}), 32'h2001);

    // 6: raw mode. The edge that sees the mode change discards its bit.
    clear_tally();
    use_stuffing = 1'b0;
    send_bit(1'b1);
    send_byte(8'h7E);
    check("raw_byte0", 32'(last_byte), 32'h7E);
    send_byte(8'hC3);
    check("raw_byte1", 32'(last_byte), 32'hC3);
    check("raw_strobes", 32'(n_strobe), 32'd2);
    check("raw_no_pulses", 32'(n_flag + n_abort + n_fend + n_ferr), 32'd0);
    clear_tally();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    use_stuffing = 1'b1;
    send_bit(1'b0);
    use_stuffing = 1'b0;
    send_bit(1'b0);
    send_byte(8'hA5);
    check("toggle_strobes", 32'(n_strobe), 32'd1);
    check("toggle_byte", 32'(last_byte), 32'hA5);

    // Reset mid-frame clears immediately; no pulses follow release.
    clear_tally();
    use_stuffing = 1'b1;
    send_bit(1'b1);
    send_byte(8'h7E);
    check("mid_open_flag", 32'(n_flag), 32'd1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    #1;
    check("async_reset_data", 32'(data_out), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    clear_tally();
    send_byte(8'h12);
    check("post_reset_hunting", 32'(n_strobe + n_flag + n_fend + n_ferr + n_abort), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
